// File: rtl/mpu_i2c_target_if.sv
// Open-drain I2C pad bundle between an I2C master (or bus model) and the MPU-6050 target.
// The master side supplies the resolved SCL/SDA levels and observes the target's pull-down enable.
interface mpu_i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe
    );

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe
    );
endinterface

// File: rtl/mpu_i2c_target.sv
// I2C target emulating the MPU-6050 register map: oversampled bus decode, pointer auto-increment,
// PWR_MGMT_1 write and coherent accelerometer/gyro sample readout.
module mpu_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter logic [7:0] WHOAMI_VAL  = 8'h68,
    parameter logic [7:0] PWR_RST_VAL = 8'h40
) (
    input  logic                   clk,
    input  logic                   resetn,
    mpu_i2c_target_if.slave        bus,
    input  logic                   sample_valid,
    input  logic [15:0]            accX,
    input  logic [15:0]            accY,
    input  logic [15:0]            accZ,
    input  logic [15:0]            gyroX,
    input  logic [15:0]            gyroY,
    input  logic [15:0]            gyroZ,
    output logic [7:0]             pwr_mgmt,
    output logic                   wr_strobe,
    output logic                   busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_MACK,
        S_WAIT
    } state_e;

    localparam logic [6:0] PWR_MGMT_ADDR = 7'h6B;
    localparam logic [6:0] WHOAMI_ADDR   = 7'h75;

    // Synchronisers plus one delayed copy for edge detection.
    logic scl_s1_q, scl_s2_q, scl_d_q;
    logic sda_s1_q, sda_s2_q, sda_d_q;

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_d_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d_q  <= 1'b1;
        end else begin
            scl_s1_q <= bus.scl_in;
            scl_s2_q <= scl_s1_q;
            scl_d_q  <= scl_s2_q;
            sda_s1_q <= bus.sda_in;
            sda_s2_q <= sda_s1_q;
            sda_d_q  <= sda_s2_q;
        end
    end

    logic scl_rise, scl_fall, bus_start, bus_stop;

    assign scl_rise  =  scl_s2_q & ~scl_d_q;
    assign scl_fall  = ~scl_s2_q &  scl_d_q;
    assign bus_start =  scl_s2_q &  scl_d_q &  sda_d_q & ~sda_s2_q;
    assign bus_stop  =  scl_s2_q &  scl_d_q & ~sda_d_q &  sda_s2_q;

    // Sample coherency: index 0..5 = accX, accY, accZ, gyroX, gyroY, gyroZ.
    logic [5:0][15:0] shadow_q;
    logic [5:0][15:0] live_q;
    logic             pend_q;
    logic             busy_q;

    // NOTE: the sample registers are a handful of flops, not a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_q <= '0;
            live_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            if (!busy_q && pend_q) begin
                live_q <= shadow_q;
                pend_q <= 1'b0;
            end
            if (sample_valid) begin
                shadow_q <= {gyroZ, gyroY, gyroX, accZ, accY, accX};
                pend_q   <= 1'b1;
            end
        end
    end

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic [7:0] pwr_q, pwr_d;
    logic       wr_stb_q, wr_stb_d;
    logic       busy_d;
    logic [7:0] rd_byte;
    logic       load_rd;

    // Register read map; sensor bytes come from the live copy only.
    always_comb begin
        rd_byte = 8'h00;
        case (ptr_q)
            7'h3B:         rd_byte = live_q[0][15:8];
            7'h3C:         rd_byte = live_q[0][7:0];
            7'h3D:         rd_byte = live_q[1][15:8];
            7'h3E:         rd_byte = live_q[1][7:0];
            7'h3F:         rd_byte = live_q[2][15:8];
            7'h40:         rd_byte = live_q[2][7:0];
            7'h43:         rd_byte = live_q[3][15:8];
            7'h44:         rd_byte = live_q[3][7:0];
            7'h45:         rd_byte = live_q[4][15:8];
            7'h46:         rd_byte = live_q[4][7:0];
            7'h47:         rd_byte = live_q[5][15:8];
            7'h48:         rd_byte = live_q[5][7:0];
            PWR_MGMT_ADDR: rd_byte = pwr_q;
            WHOAMI_ADDR:   rd_byte = WHOAMI_VAL;
            default:       rd_byte = 8'h00;
        endcase
    end

    // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        ptr_d    = ptr_q;
        oe_d     = oe_q;
        pwr_d    = pwr_q;
        wr_stb_d = 1'b0;
        busy_d   = busy_q;
        load_rd  = 1'b0;

        if (bus_stop) begin
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end else if (bus_start) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        rx_d  = {rx_q[6:0], sda_s2_q};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (rx_q[7:1] == DEV_ADDR) begin
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rx_q[0]) begin
                            load_rd = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_REG;
                        end
                    end
                end
                S_REG, S_WDATA: begin
                    if (scl_rise) begin
                        rx_d  = {rx_q[6:0], sda_s2_q};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d = 1'b1;
                        if (state_q == S_REG) begin
                            ptr_d   = rx_q[6:0];
                            state_d = S_REG_ACK;
                        end else begin
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
                S_REG_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_WDATA;
                    end
                end
                S_WDATA_ACK: begin
                    if (scl_rise) begin
                        if (ptr_q == PWR_MGMT_ADDR) begin
                            pwr_d = rx_q;
                        end
                        wr_stb_d = 1'b1;
                        ptr_d    = ptr_q + 7'd1;
                    end else if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = S_RDATA_MACK;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                            oe_d = ~tx_q[6];
                        end
                    end
                end
                S_RDATA_MACK: begin
                    // rx_q[0] holds the master's acknowledge level sampled on the 9th rise.
                    if (scl_rise) begin
                        rx_d[0] = sda_s2_q;
                    end else if (scl_fall) begin
                        if (!rx_q[0]) begin
                            load_rd = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (load_rd) begin
            tx_d    = rd_byte;
            oe_d    = ~rd_byte[7];
            ptr_d   = ptr_q + 7'd1;
            cnt_d   = 4'd0;
            state_d = S_RDATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rx_q     <= 8'h00;
            tx_q     <= 8'h00;
            ptr_q    <= 7'h00;
            oe_q     <= 1'b0;
            pwr_q    <= PWR_RST_VAL;
            wr_stb_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            ptr_q    <= ptr_d;
            oe_q     <= oe_d;
            pwr_q    <= pwr_d;
            wr_stb_q <= wr_stb_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.sda_oe = oe_q;
    assign pwr_mgmt   = pwr_q;
    assign wr_strobe  = wr_stb_q;
    assign busy       = busy_q;

endmodule
